// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one registered W x W signed multiplier
// among NREQ requesters, returning ID-tagged products over a valid/ready port.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 9,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  output logic              mul_en,
  input  logic [2*W-2:0]    mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-2:0]    rsp_p,
  output logic              busy,
  output logic [CNTW-1:0]   ops_done
);
  typedef enum logic [1:0] {IDLE, MUL, RSP} state_t;
  state_t state;
  logic [IDW-1:0] rr_ptr, g;
  logic any;
  function automatic logic [IDW-1:0] wrap(input int v);
    return IDW'(v >= NREQ ? v - NREQ : v);
  endfunction
  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    g = '0;
    any = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[wrap(int'(rr_ptr) + k)]) begin
        g = wrap(int'(rr_ptr) + k);
        any = 1'b1;
      end
    req_ready = '0;
    if (state == IDLE && rst_n && any) req_ready[g] = 1'b1;
  end
  assign rsp_valid = state == RSP;
  assign rsp_p = rsp_valid ? mul_p : '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mul_a <= '0;
      mul_b <= '0;
      mul_en <= 1'b0;
      rsp_id <= '0;
      rr_ptr <= '0;
      ops_done <= '0;
    end else
      case (state)
        IDLE: if (any) begin
          mul_a <= req_a[g*W +: W];
          mul_b <= req_b[g*W +: W];
          rsp_id <= g;
          rr_ptr <= wrap(int'(g) + 1);
          mul_en <= 1'b1;
          state <= MUL;
        end
        MUL: begin
          mul_en <= 1'b0;
          state <= RSP;
        end
        RSP: if (rsp_ready) begin
          ops_done <= &ops_done ? ops_done : ops_done + CNTW'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one registered 9x9 signed array multiplier between NREQ requesters.
- The multiplier takes operands A and B and an enable `en`, and registers product P one clock after `en`.
- This block arbitrates round-robin among requesters, presents the winner's operands, pulses the multiplier enable, and returns the registered product tagged with the requester ID over a valid/ready response port.
- It sits between the requesters and the multiplier instance at the same level of hierarchy.

Parameters:
- NREQ, 4, number of requesters (2..8).
- W, 9, operand width in bits; the multiplier is W x W signed.
- IDW, 2, width of the requester ID; must equal ceil(log2(NREQ)).
- CNTW, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept (one-hot or zero).
- req_a  in  NREQ*W  packed multiplicands; requester i uses bits [i*W +: W].
- req_b  in  NREQ*W  packed multipliers; same packing as req_a.
- mul_a  out  W  operand A to the multiplier (registered).
- mul_b  out  W  operand B to the multiplier (registered).
- mul_en  out  1  multiplier enable (registered); a 1-cycle pulse per operation.
- mul_p  in  2W-1  registered product from the multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  ID of the requester that owns rsp_p.
- rsp_p  out  2W-1  signed product.
- busy  out  1  high whenever the FSM is not IDLE.
- ops_done  out  CNTW  count of completed response handshakes.

Behaviour:
- Clocking and reset:
  - Single clock; asynchronous, active-low reset (clk / rst_n).
  - Reset values: req_ready=0, mul_a=0, mul_b=0, mul_en=0, rsp_valid=0, rsp_id=0, rsp_p=0, busy=0, ops_done=0, rr_ptr=0, state=IDLE.
- FSM states: IDLE, MUL, RSP.
- IDLE:
  - If any req_valid is high, the grant g is the first requester with req_valid high, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle; this is the handshake. Other req_ready bits are 0.
  - On the clock edge:
    - mul_a <= req_a[g];
    - mul_b <= req_b[g];
    - id register <= g;
    - rr_ptr <= (g+1) mod NREQ;
    - mul_en <= 1;
    - state -> MUL.
  - If no req_valid is high, nothing changes.
- MUL:
  - mul_en=1 for exactly this cycle, so the multiplier captures the product at the end of it.
  - All req_ready=0.
  - Next state is RSP; mul_en <= 0.
- RSP:
  - rsp_valid=1.
  - rsp_p is driven combinationally from mul_p, which is stable because mul_en is low.
  - rsp_id = id register.
  - rsp_p, rsp_id and rsp_valid stay stable until rsp_ready is sampled high.
  - On rsp_valid && rsp_ready: ops_done <= ops_done+1, saturating at all-ones; state -> IDLE.
  - All req_ready=0 in RSP.
- Timing:
  - Request accepted at cycle t: mul_en high in t+1, rsp_valid high from t+2.
  - Minimum spacing between accepts is 3 cycles (t, t+3, ...).
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
- A requester whose req_valid drops before it is granted is simply skipped; nothing is latched for it.
- Arithmetic:
  - The block does not modify the product; rsp_p equals mul_p bit-for-bit.
  - Product width is 2W-1. The single overflow case (-2^(W-1)) x (-2^(W-1)) wraps; for W=9 it returns 17'h10000. This is documented and accepted behaviour.
- Reset asserted mid-operation, in any state: all outputs return to their reset values immediately. The in-flight operation is dropped with no response, and rr_ptr returns to 0.
- busy = (state != IDLE).

Test Plan:
- Single request: req 1 valid with A=3, B=-5 -> req_ready[1] high same cycle; mul_en pulses next cycle; rsp_valid two cycles after accept with rsp_id=1, rsp_p=17'h1FFF1 (-15); ops_done=1.
- Round-robin: all 4 valid continuously with distinct operands (i+1)x(i+2), rsp_ready tied high -> grants in order 0,1,2,3,0 every 3 cycles; products 2,6,12,20.
- Back-pressure: rsp_ready low for 5 cycles in RSP with A=-256, B=127 -> rsp_p=-32512 stable and rsp_valid held; no new req_ready until the handshake; then IDLE.
- Overflow corner: A=-256, B=-256 -> rsp_p=17'h10000.
- Reset mid-op: assert rst_n low during MUL -> all outputs 0 at once, no response emitted after release, next grant starts from requester 0.
- Counter saturation: with CNTW=4, run 17 operations -> ops_done stops at 15.
